// File: rtl/music_sequencer_pkg.sv
// Shared types and constants for the score sequencer: FSM states, score-word
// layout, note-code nibble positions and the note-code legality check.
package music_sequencer_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_FETCH = S_FETCH,
        ST_LOAD  = S_LOAD,
        ST_PLAY  = S_PLAY,
        ST_PAUSE = S_PAUSE,
        ST_DONE  = S_DONE
    } state_e;

    localparam int WORD_W   = 16;
    localparam int DUR_MSB  = 15;
    localparam int DUR_LSB  = 12;
    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 0;

    localparam logic [11:0] NOTE_REST = 12'h000;
    localparam int NIB_LOW  = 0;
    localparam int NIB_MID  = 1;
    localparam int NIB_HIGH = 2;

    // Short ascending phrase, word 0 in the least significant 16 bits.
    localparam logic [127:0] DEFAULT_SCORE = {
        16'h0000, 16'h4010, 16'h2000, 16'h2005,
        16'h1004, 16'h1003, 16'h1002, 16'h1001
    };

    // Legal codes: rest, or exactly one octave nibble holding a note 1..7.
    function automatic logic note_legal(input logic [11:0] code);
        int nz_cnt;
        logic ok;
        nz_cnt = 0;
        ok     = 1'b1;
        for (int i = NIB_LOW; i <= NIB_HIGH; i++) begin
            if (code[4*i+3]) ok = 1'b0;
            if (code[4*i +: 4] != 4'd0) nz_cnt++;
        end
        if (nz_cnt > 1) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/music_sequencer_score_rom.sv
// Synchronous-read score ROM; contents come from the packed SCORE image,
// word n occupying bits [16n+15:16n].
module score_rom
    import music_sequencer_pkg::*;
#(
    parameter int AW = 8,
    parameter logic [WORD_W*(2**AW)-1:0] SCORE = '0
) (
    input  logic              clk_5m,
    input  logic [AW-1:0]     addr,
    output logic [WORD_W-1:0] data
);

    localparam int DEPTH = 2**AW;

    logic [WORD_W-1:0] mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            assign mem[gi] = SCORE[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk_5m) begin
        data <= mem[addr];
    end

endmodule

// File: rtl/music_sequencer.sv
// Score sequencer: walks (duration, note) words from the score ROM and holds
// each note code on din for its duration in beats, with play/pause/stop control.
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int BEAT_DIV = 1250000,
    parameter int AW       = 8,
    parameter int LOOP     = 1,
    parameter logic [WORD_W*(2**AW)-1:0] SCORE = (WORD_W*(2**AW))'(DEFAULT_SCORE)
) (
    input  logic          clk_5m,
    input  logic          rst_n,
    input  logic          play,
    input  logic          pause,
    input  logic          stop,
    output logic [11:0]   din,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic          err
);

    localparam int DIV_W = $clog2(BEAT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);

    state_e            state_reg, state_next;
    logic [AW-1:0]     addr_reg, addr_next;
    logic [11:0]       note_reg, note_next;
    logic [11:0]       din_reg, din_next;
    logic [3:0]        beats_reg, beats_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;

    logic [WORD_W-1:0] rom_data;
    logic [3:0]        dur;
    logic [11:0]       code;
    logic              beat_tick;
    logic              note_end;

    score_rom #(
        .AW    (AW),
        .SCORE (SCORE)
    ) u_rom (
        .clk_5m (clk_5m),
        .addr   (addr_reg),
        .data   (rom_data)
    );

    assign dur       = rom_data[DUR_MSB:DUR_LSB];
    assign code      = rom_data[NOTE_MSB:NOTE_LSB];
    assign beat_tick = (div_reg == DIV_LAST);
    assign note_end  = beat_tick && (beats_reg <= 4'd1);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        note_next  = note_reg;
        beats_next = beats_reg;
        div_next   = div_reg;
        err_next   = err_reg;

        if (stop) begin
            state_next = ST_IDLE;
            addr_next  = '0;
            note_next  = NOTE_REST;
            beats_next = '0;
            div_next   = '0;
            err_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (play) state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    if (dur == 4'd0) begin
                        if (LOOP != 0) begin
                            addr_next  = '0;
                            state_next = ST_FETCH;
                        end else begin
                            note_next  = NOTE_REST;
                            state_next = ST_DONE;
                        end
                    end else begin
                        note_next  = note_legal(code) ? code : NOTE_REST;
                        err_next   = err_reg | ~note_legal(code);
                        beats_next = dur;
                        div_next   = '0;
                        state_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // The cycle in which pause is sampled still counts, so every
                    // PLAY cycle contributes to the note length.
                    if (beat_tick) begin
                        div_next = '0;
                        if (note_end) begin
                            addr_next  = addr_reg + AW'(1);
                            state_next = ST_FETCH;
                        end else begin
                            beats_next = beats_reg - 4'd1;
                        end
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                    // A pause landing on the note's last cycle falls into FETCH and is dropped.
                    if (pause && !note_end) state_next = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (play) state_next = ST_PLAY;
                end
                ST_DONE: begin
                    if (play) begin
                        addr_next  = '0;
                        state_next = ST_FETCH;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        busy_next = (state_next == ST_FETCH) || (state_next == ST_LOAD) ||
                    (state_next == ST_PLAY)  || (state_next == ST_PAUSE);
        din_next  = ((state_next == ST_FETCH) || (state_next == ST_LOAD) ||
                     (state_next == ST_PLAY)) ? note_next : NOTE_REST;
    end

    always_ff @(posedge clk_5m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            note_reg  <= NOTE_REST;
            din_reg   <= NOTE_REST;
            beats_reg <= '0;
            div_reg   <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            note_reg  <= note_next;
            din_reg   <= din_next;
            beats_reg <= beats_next;
            div_reg   <= div_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    assign din  = din_reg;
    assign busy = busy_reg;
    assign addr = addr_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench: three sequencers share clock and controls (one-shot score,
// looping score, illegal-code score) and are checked cycle by cycle.
module tb_music_sequencer;

    logic        clk_5m = 1'b0;
    logic        rst_n;
    logic        play, pause, stop;

    logic [11:0] a_din, l_din, i_din;
    logic        a_busy, l_busy, i_busy;
    logic [1:0]  a_addr, l_addr, i_addr;
    logic        a_err, l_err, i_err;

    int total    = 0;
    int pass_cnt = 0;

    always #5 clk_5m = ~clk_5m;

    music_sequencer #(.BEAT_DIV(4), .AW(2), .LOOP(0),
                      .SCORE(64'h0000_0000_1010_2001)) u_a (
        .clk_5m(clk_5m), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop),
        .din(a_din), .busy(a_busy), .addr(a_addr), .err(a_err));

    music_sequencer #(.BEAT_DIV(4), .AW(2), .LOOP(1),
                      .SCORE(64'h0000_0000_1010_2001)) u_l (
        .clk_5m(clk_5m), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop),
        .din(l_din), .busy(l_busy), .addr(l_addr), .err(l_err));

    music_sequencer #(.BEAT_DIV(4), .AW(2), .LOOP(0),
                      .SCORE(64'h0000_0000_0000_1011)) u_i (
        .clk_5m(clk_5m), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop),
        .din(i_din), .busy(i_busy), .addr(i_addr), .err(i_err));

    task automatic tick();
        @(posedge clk_5m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
        $display("check %-14s observed %h expected %h", tag, got, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        play  = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        repeat (3) tick();
        chk("rst_din",  {4'h0, a_din},   16'h0000);
        chk("rst_busy", {15'h0, a_busy}, 16'h0000);
        chk("rst_addr", {14'h0, a_addr}, 16'h0000);
        chk("rst_err",  {15'h0, a_err},  16'h0000);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {15'h0, a_busy}, 16'h0000);

        // Basic playback, looping and illegal code run side by side.
        play = 1'b1;
        tick();
        play = 1'b0;
        chk("fetch_busy", {15'h0, a_busy}, 16'h0001);
        chk("fetch_din",  {4'h0, a_din},   16'h0000);
        tick();
        chk("load_din",   {4'h0, a_din},   16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("note1_din",   {4'h0, a_din}, 16'h0001);
            chk("loop1_din",   {4'h0, l_din}, 16'h0001);
            chk("ill_din",     {4'h0, i_din}, 16'h0000);
            if (i == 0) chk("ill_err_set", {15'h0, i_err}, 16'h0001);
            if (i == 3) chk("ill_busy",    {15'h0, i_busy}, 16'h0001);
            if (i == 6) chk("ill_done",    {15'h0, i_busy}, 16'h0000);
            if (i == 8) chk("note1_addr",  {14'h0, a_addr}, 16'h0001);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("note2_din", {4'h0, a_din}, 16'h0010);
            chk("loop2_din", {4'h0, l_din}, 16'h0010);
        end
        tick();
        chk("done_din",     {4'h0, a_din},   16'h0000);
        chk("done_busy",    {15'h0, a_busy}, 16'h0000);
        chk("loop_addr0",   {14'h0, l_addr}, 16'h0000);
        chk("loop_busy",    {15'h0, l_busy}, 16'h0001);
        chk("loop_hold",    {4'h0, l_din},   16'h0010);
        tick();
        chk("loop_load",    {4'h0, l_din},   16'h0010);
        tick();
        chk("loop_again",   {4'h0, l_din},   16'h0001);
        tick();
        chk("err_sticky",   {15'h0, i_err},  16'h0001);

        // Stop beats play in the same cycle, mid-note on the looping unit.
        stop = 1'b1;
        play = 1'b1;
        tick();
        stop = 1'b0;
        play = 1'b0;
        chk("stop_busy",  {15'h0, l_busy}, 16'h0000);
        chk("stop_din",   {4'h0, l_din},   16'h0000);
        chk("stop_addr",  {14'h0, l_addr}, 16'h0000);
        chk("stop_aaddr", {14'h0, a_addr}, 16'h0000);
        chk("stop_err",   {15'h0, i_err},  16'h0000);
        tick();
        chk("stop_idle",  {15'h0, l_busy}, 16'h0000);

        // Pause during the third cycle of the first note, resume 20 cycles later.
        play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pre_pause", {4'h0, a_din}, 16'h0001);
        end
        pause = 1'b1;
        tick();
        pause = 1'b0;
        chk("pause_din",  {4'h0, a_din},   16'h0000);
        chk("pause_busy", {15'h0, a_busy}, 16'h0001);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk("paused_din", {4'h0, a_din}, 16'h0000);
        end
        play = 1'b1;
        tick();
        play = 1'b0;
        chk("resume_din", {4'h0, a_din}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("resume_din",  {4'h0, a_din},  16'h0001);
            chk("resume_addr", {14'h0, a_addr}, 16'h0000);
        end
        tick();
        chk("resume_next", {14'h0, a_addr}, 16'h0001);
        chk("resume_hold", {4'h0, a_din},   16'h0001);
        tick();
        tick();
        chk("resume_n2",   {4'h0, a_din},   16'h0010);
        chk("pre_rst_err", {15'h0, i_err},  16'h0001);

        // Asynchronous reset mid-note, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_din",  {4'h0, a_din},   16'h0000);
        chk("arst_busy", {15'h0, a_busy}, 16'h0000);
        chk("arst_addr", {14'h0, a_addr}, 16'h0000);
        chk("arst_err",  {15'h0, i_err},  16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst",  {15'h0, a_busy}, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
